// File: rtl/serial_pkg.sv
// Shared definitions for the serial loader: ASCII tokens, receiver and parser
// state encodings, and the hex-digit decoder.
package serial_pkg;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_CR     = 8'd13;
  localparam logic [7:0] CH_STAR   = 8'h2A;

  // The CSUM_* states are reachable only when the checksum trailer is enabled.
  typedef enum logic [2:0] {
    IDLE, ADDR, DATA_HI, DATA_LO, DONE, CSUM_HI, CSUM_LO, CSUM_END
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_t;

  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t h;
    h.valid = 1'b1;
    h.nib   = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)      h.nib = 4'(c - 8'h30);
    else if (c >= 8'h41 && c <= 8'h46) h.nib = 4'(c - 8'h37);
    else if (c >= 8'h61 && c <= 8'h66) h.nib = 4'(c - 8'h57);
    else                               h.valid = 1'b0;
    return h;
  endfunction

endpackage

// File: rtl/serial_rx.sv
// Bit-level 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling,
// start-bit glitch rejection, one-cycle rx_valid / rx_ferr strobes.
module serial_rx #(
  parameter int CLK_HZ = 24000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);
  import serial_pkg::*;

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CNT_W   = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BIT_CYC / 2 - 1);

  rx_state_t        state;
  logic [2:0]       sync;     // [1] is the synchronized line, [2] its previous value
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  always_ff @(posedge clk) begin
    if (RESET) begin
      // Synchronizer presets to the idle level so leaving reset is not seen as a start bit.
      sync     <= 3'b111;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      // NOTE: all state here is updated with non-blocking assignments so every
      // register samples the values from before this edge, matching real flops.
      sync     <= {sync[1:0], rx};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (sync[2] && !sync[1]) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync[1] ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shift <= {sync[1], shift[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (sync[1]) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_loader.sv
// UART-to-RAM loader parsing "$AAAA#HH HH ... HH<CR>" into RAM writes.
// SERIAL_LOADER_CHECKSUM_EN adds a mandatory "*CC" trailer before CR.
module serial_loader #(
  parameter int CLK_HZ = 24000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              RxPin,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       byte_count
);
  import serial_pkg::*;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  serial_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .RESET    (RESET),
    .rx       (RxPin),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  parse_state_t      state;
  logic [2:0]        digit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        hi_nib;
  hex_t              hx;
  logic [7:0]        data_byte;
  logic              abort;
`ifdef SERIAL_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
  logic [3:0]        ck_hi;
  logic              ck_ok;
`endif

  assign hx        = hex_decode(rx_byte);
  assign data_byte = {hi_nib, hx.nib};

  // Any byte that cannot continue the open frame ('$' always restarts instead).
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    abort = 1'b0;
    if (rx_ferr && state != IDLE) begin
      abort = 1'b1;
    end else if (rx_valid && rx_byte != CH_DOLLAR) begin
      case (state)
        ADDR:    abort = (digit_cnt == 3'd4) ? (rx_byte != CH_HASH) : !hx.valid;
`ifdef SERIAL_LOADER_CHECKSUM_EN
        DATA_HI: abort = !(hx.valid || rx_byte == CH_SPACE || rx_byte == CH_STAR);
        CSUM_HI,
        CSUM_LO: abort = !hx.valid;
        CSUM_END: abort = (rx_byte != CH_CR) || !ck_ok;
`else
        DATA_HI: abort = !(hx.valid || rx_byte == CH_SPACE || rx_byte == CH_CR);
`endif
        DATA_LO: abort = !hx.valid;
        default: abort = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      digit_cnt  <= '0;
      addr       <= '0;
      hi_nib     <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      byte_count <= '0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
      sum        <= '0;
      ck_hi      <= '0;
      ck_ok      <= 1'b0;
`endif
    end else begin
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (state == DONE) begin
        frame_done <= 1'b1;
        busy       <= 1'b0;
        state      <= IDLE;
      end else if (abort) begin
        frame_err <= 1'b1;
        busy      <= 1'b0;
        state     <= IDLE;
      end else if (rx_valid) begin
        if (rx_byte == CH_DOLLAR) begin
          state      <= ADDR;
          digit_cnt  <= '0;
          byte_count <= '0;
          busy       <= 1'b1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
          sum        <= '0;
`endif
        end else begin
          case (state)
            ADDR: begin
              // Shifting into an ADDR_W-wide register keeps only the low address bits.
              if (digit_cnt == 3'd4) begin
                state <= DATA_HI;
              end else begin
                addr      <= ADDR_W'({addr, hx.nib});
                digit_cnt <= digit_cnt + 1'b1;
              end
            end
            DATA_HI: begin
              if (hx.valid) begin
                hi_nib <= hx.nib;
                state  <= DATA_LO;
`ifdef SERIAL_LOADER_CHECKSUM_EN
              end else if (rx_byte == CH_STAR) begin
                state <= CSUM_HI;
`else
              end else if (rx_byte == CH_CR) begin
                state <= DONE;
`endif
              end
            end
            DATA_LO: begin
              ram_we   <= 1'b1;
              ram_addr <= addr;
              ram_data <= data_byte;
              addr     <= addr + ADDR_W'(1);
              if (byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
              sum      <= sum + data_byte;
`endif
              state    <= DATA_HI;
            end
`ifdef SERIAL_LOADER_CHECKSUM_EN
            CSUM_HI: begin
              ck_hi <= hx.nib;
              state <= CSUM_LO;
            end
            CSUM_LO: begin
              ck_ok <= ({ck_hi, hx.nib} + sum) == 8'h00;
              state <= CSUM_END;
            end
            CSUM_END: state <= DONE;
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule
